// File: rtl/mac_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mac_array_ctrl_pkg
//  Purpose : Shared NPU definitions for the MAC array controller: FSM state
//            encoding, config legality limits and a helper that derives the
//            largest kernel height an array of a given size can run.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mac_array_ctrl_pkg;

    // Controller states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Allowed convolution strides (inclusive range).
    localparam logic [2:0] c_STRIDE_MIN = 3'd1;
    localparam logic [2:0] c_STRIDE_MAX = 3'd2;

    // Largest value the 3-bit kernel field can carry.
    localparam int c_K_FIELD_MAX = 7;

    // Max legal kernel height: one PE row per kernel row, capped by the field.
    function automatic int k_limit(input int num_rows);
        return (num_rows < c_K_FIELD_MAX) ? num_rows : c_K_FIELD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : mac_array_ctrl_if
//  Purpose : Bundles the layer-config handshake and the per-row MAC control
//            signals of the MAC array controller.
//  Ports   : cfg_valid/cfg_ready/cfg_* - layer config handshake and fields
//            cfg_err                    - rejected-config pulse
//            K/IMG_W/OC/STRIDE          - latched config broadcast to MACs
//            mac_start/mac_done         - per-row start pulse / idle level
//            is_bottom                  - bottom row of the psum chain
//            out_row/ia_row_idx         - current output row / first input row
//            row_done/layer_done/busy   - progress pulses and busy level
//  Modports: slave  - the controller
//            master - the environment (config source and MAC rows)
//  Rev     : 1.0  initial release
// ============================================================================
interface mac_array_ctrl_if #(
    parameter int NUM_ROWS = 3
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_k;
    logic [5:0]          cfg_img_w;
    logic [7:0]          cfg_oc;
    logic [2:0]          cfg_stride;
    logic [5:0]          cfg_out_h;
    logic                cfg_err;

    logic [2:0]          K;
    logic [5:0]          IMG_W;
    logic [7:0]          OC;
    logic [2:0]          STRIDE;

    logic [NUM_ROWS-1:0] mac_start;
    logic [NUM_ROWS-1:0] mac_done;
    logic [NUM_ROWS-1:0] is_bottom;

    logic [5:0]          out_row;
    logic [7:0]          ia_row_idx;
    logic                row_done;
    logic                layer_done;
    logic                busy;

    modport slave (
        input  cfg_valid, cfg_k, cfg_img_w, cfg_oc, cfg_stride, cfg_out_h,
        input  mac_done,
        output cfg_ready, cfg_err, K, IMG_W, OC, STRIDE,
        output mac_start, is_bottom, out_row, ia_row_idx,
        output row_done, layer_done, busy
    );

    modport master (
        output cfg_valid, cfg_k, cfg_img_w, cfg_oc, cfg_stride, cfg_out_h,
        output mac_done,
        input  cfg_ready, cfg_err, K, IMG_W, OC, STRIDE,
        input  mac_start, is_bottom, out_row, ia_row_idx,
        input  row_done, layer_done, busy
    );

endinterface
`default_nettype wire

// File: rtl/mac_array_ctrl_cfg_check.sv
`default_nettype none
// ============================================================================
//  Module  : mac_cfg_check
//  Purpose : Purely combinational legality check of an incoming layer config.
//  Ports   : i_cfg_k, i_cfg_img_w, i_cfg_oc, i_cfg_stride, i_cfg_out_h
//                       - candidate layer parameters
//            o_illegal  - 1 when the config must be rejected
//  Rev     : 1.0  initial release
// ============================================================================
module mac_cfg_check
    import mac_array_ctrl_pkg::*;
#(
    parameter int NUM_ROWS          = 3,
    parameter int PSUM_ROW_MEM_ADDR = 12
) (
    input  wire logic [2:0] i_cfg_k,
    input  wire logic [5:0] i_cfg_img_w,
    input  wire logic [7:0] i_cfg_oc,
    input  wire logic [2:0] i_cfg_stride,
    input  wire logic [5:0] i_cfg_out_h,
    output logic            o_illegal
);

    localparam logic [63:0] c_PSUM_LIMIT = 64'd1 << PSUM_ROW_MEM_ADDR;

    logic [63:0] w_prod;
    logic        w_k_bad;
    logic        w_stride_bad;
    logic        w_dim_bad;
    logic        w_psum_bad;

    // Widened before multiplying so the full OC*IMG_W product survives.
    assign w_prod       = 64'(i_cfg_oc) * 64'(i_cfg_img_w);

    assign w_k_bad      = (i_cfg_k == 3'd0) || (int'(i_cfg_k) > k_limit(NUM_ROWS));
    assign w_stride_bad = (i_cfg_stride < c_STRIDE_MIN) || (i_cfg_stride > c_STRIDE_MAX);
    assign w_dim_bad    = (i_cfg_img_w == 6'd0) || (i_cfg_oc == 8'd0) || (i_cfg_out_h == 6'd0);
    assign w_psum_bad   = (w_prod > c_PSUM_LIMIT);

    assign o_illegal    = w_k_bad || w_stride_bad || w_dim_bad || w_psum_bad;

endmodule
`default_nettype wire

// File: rtl/mac_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mac_array_ctrl
//  Purpose : Sequences one output row at a time through an array of NUM_ROWS
//            MAC rows: start the K active rows, wait for all of them to go
//            idle, let the psum chain flush, then advance to the next output
//            row until the layer is complete.
//  Ports   : clk    - rising-edge clock
//            reset  - synchronous active-high reset
//            bus    - mac_array_ctrl_if.slave (config handshake, latched
//                     config, per-row start/done, progress outputs)
//  Rev     : 1.0  initial release
// ============================================================================
module mac_array_ctrl
    import mac_array_ctrl_pkg::*;
#(
    parameter int NUM_ROWS          = 3,
    parameter int DRAIN_CYC         = 4,
    parameter int PSUM_ROW_MEM_ADDR = 12
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mac_array_ctrl_if.slave   bus
);

    localparam int                 c_CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [2:0]           r_k;
    logic [5:0]           r_img_w;
    logic [7:0]           r_oc;
    logic [2:0]           r_stride;
    logic [5:0]           r_out_h;
    logic [5:0]           r_out_row;
    logic [7:0]           r_ia_row;
    logic [c_CNT_W-1:0]   r_drain_cnt;
    logic                 r_cfg_err;

    logic                 w_cfg_ready;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_load;
    logic                 w_drain_last;
    logic                 w_row_last;
    logic                 w_all_done;
    logic [NUM_ROWS-1:0]  w_active_mask;
    logic [NUM_ROWS-1:0]  w_is_bottom;
    logic [NUM_ROWS-1:0]  w_mac_start;
    logic                 w_row_done;
    logic                 w_layer_done;

    mac_cfg_check #(
        .NUM_ROWS          (NUM_ROWS),
        .PSUM_ROW_MEM_ADDR (PSUM_ROW_MEM_ADDR)
    ) u_cfg_check (
        .i_cfg_k      (bus.cfg_k),
        .i_cfg_img_w  (bus.cfg_img_w),
        .i_cfg_oc     (bus.cfg_oc),
        .i_cfg_stride (bus.cfg_stride),
        .i_cfg_out_h  (bus.cfg_out_h),
        .o_illegal    (w_illegal)
    );

    // Ready drops for the error-pulse cycle so a held illegal config cannot
    // produce back-to-back error pulses.
    assign w_cfg_ready  = (r_state == ST_IDLE) && !r_cfg_err;
    assign w_accept     = w_cfg_ready && bus.cfg_valid;
    assign w_load       = w_accept && !w_illegal;
    assign w_drain_last = (r_drain_cnt == '0);
    assign w_row_last   = (r_out_row == (r_out_h - 6'd1));
    assign w_all_done   = ((bus.mac_done & w_active_mask) == w_active_mask);

    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            assign w_active_mask[i] = (i < int'(r_k));
            // K==0 (after reset) leaves every bit low.
            assign w_is_bottom[i]   = ((i + 1) == int'(r_k));
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and pulse outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_mac_start  = '0;
        w_row_done   = 1'b0;
        w_layer_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_mac_start = w_active_mask;
                w_state_nxt = ST_ARM;
            end
            // MAC done is still the stale idle level here; it only drops one
            // cycle after start, so it is not looked at in this state.
            ST_ARM: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_all_done) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_last) begin
                    w_row_done  = 1'b1;
                    w_state_nxt = w_row_last ? ST_DONE : ST_START;
                end
            end
            ST_DONE: begin
                w_layer_done = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Config latch, row/offset counters, drain counter, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k         <= '0;
            r_img_w     <= '0;
            r_oc        <= '0;
            r_stride    <= '0;
            r_out_h     <= '0;
            r_out_row   <= '0;
            r_ia_row    <= '0;
            r_drain_cnt <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && w_illegal;

            if (w_load) begin
                r_k       <= bus.cfg_k;
                r_img_w   <= bus.cfg_img_w;
                r_oc      <= bus.cfg_oc;
                r_stride  <= bus.cfg_stride;
                r_out_h   <= bus.cfg_out_h;
                r_out_row <= '0;
                r_ia_row  <= '0;
            end

            // Preload while waiting so DRAIN lasts exactly DRAIN_CYC cycles.
            if (r_state == ST_WAIT) begin
                r_drain_cnt <= c_DRAIN_LAST;
            end else if ((r_state == ST_DRAIN) && !w_drain_last) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end

            if ((r_state == ST_DRAIN) && w_drain_last && !w_row_last) begin
                r_out_row <= r_out_row + 6'd1;
                r_ia_row  <= r_ia_row + {5'd0, r_stride};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; pulses are masked while reset is held so an aborted layer
    // never emits anything.
    // ------------------------------------------------------------------
    assign bus.cfg_ready  = w_cfg_ready;
    assign bus.cfg_err    = r_cfg_err && !reset;
    assign bus.K          = r_k;
    assign bus.IMG_W      = r_img_w;
    assign bus.OC         = r_oc;
    assign bus.STRIDE     = r_stride;
    assign bus.mac_start  = reset ? '0 : w_mac_start;
    assign bus.is_bottom  = w_is_bottom;
    assign bus.out_row    = r_out_row;
    assign bus.ia_row_idx = r_ia_row;
    assign bus.row_done   = w_row_done && !reset;
    assign bus.layer_done = w_layer_done && !reset;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
